// File: rtl/branch_predictor.sv
// Fetch-stage branch predictor: direct-mapped BTB, one 2-bit saturating
// counter per entry, trained from the EX-stage branch resolution. Also
// flags EX mispredictions, supplies the redirect PC, and keeps perf counts.
module branch_predictor #(
  parameter int unsigned ENTRIES  = 64,
  parameter logic [1:0]  CNT_INIT = 2'b01
) (
  input  logic        CPU_CLK,
  input  logic        CPU_RST_N,
  input  logic [31:0] PCF,
  output logic        PredTakenF,
  output logic [31:0] PredTargetF,
  input  logic [2:0]  BranchTypeE,
  input  logic        BranchE,
  input  logic [31:0] PCE,
  input  logic [31:0] BranchTargetE,
  input  logic        PredTakenE,
  input  logic [31:0] PredTargetE,
  input  logic        StallE,
  output logic        MispredictE,
  output logic [31:0] CorrectPCE,
  output logic [31:0] BranchCnt,
  output logic [31:0] MispredCnt
);

  localparam int unsigned IDX_W = $clog2(ENTRIES);
  localparam int unsigned TAG_W = 32 - IDX_W - 2;

  logic             valid_q  [ENTRIES];
  logic             valid_d  [ENTRIES];
  logic [TAG_W-1:0] tag_q    [ENTRIES];
  logic [TAG_W-1:0] tag_d    [ENTRIES];
  logic [31:0]      target_q [ENTRIES];
  logic [31:0]      target_d [ENTRIES];
  logic [1:0]       ctr_q    [ENTRIES];
  logic [1:0]       ctr_d    [ENTRIES];

  logic [31:0] branch_cnt_q, branch_cnt_d;
  logic [31:0] mispred_cnt_q, mispred_cnt_d;

  logic [IDX_W-1:0] idx_f, idx_e;
  logic [TAG_W-1:0] tag_f, tag_e;
  logic             hit_f, hit_e;
  logic             is_branch_e;
  logic             upd_e;

  // Fetch lookup against the pre-edge table state (zero-cycle prediction)
  always_comb begin
    idx_f       = PCF[IDX_W+1:2];
    tag_f       = PCF[31:IDX_W+2];
    hit_f       = valid_q[idx_f] && (tag_q[idx_f] == tag_f);
    PredTakenF  = hit_f && ctr_q[idx_f][1];
    PredTargetF = PredTakenF ? target_q[idx_f] : PCF + 32'd4;
  end

  // EX-stage misprediction detect and redirect target; ignores StallE so
  // the consumer can qualify it with its own stall
  always_comb begin
    is_branch_e = (BranchTypeE != 3'd0);
    if (is_branch_e) begin
      MispredictE = (PredTakenE != BranchE) ||
                    (BranchE && PredTakenE && (PredTargetE != BranchTargetE));
    end else begin
      // a taken prediction on a non-branch came from a stale/aliased entry
      MispredictE = PredTakenE;
    end
    CorrectPCE = (is_branch_e && BranchE) ? BranchTargetE : PCE + 32'd4;
  end

  // Table training: strengthen/weaken on hit, allocate only on taken miss
  always_comb begin
    valid_d  = valid_q;
    tag_d    = tag_q;
    target_d = target_q;
    ctr_d    = ctr_q;
    idx_e    = PCE[IDX_W+1:2];
    tag_e    = PCE[31:IDX_W+2];
    hit_e    = valid_q[idx_e] && (tag_q[idx_e] == tag_e);
    upd_e    = is_branch_e && !StallE;
    if (upd_e) begin
      if (hit_e) begin
        if (BranchE) begin
          if (ctr_q[idx_e] != 2'b11) ctr_d[idx_e] = ctr_q[idx_e] + 2'd1;
          target_d[idx_e] = BranchTargetE;
        end else begin
          if (ctr_q[idx_e] != 2'b00) ctr_d[idx_e] = ctr_q[idx_e] - 2'd1;
        end
      end else if (BranchE) begin
        valid_d[idx_e]  = 1'b1;
        tag_d[idx_e]    = tag_e;
        target_d[idx_e] = BranchTargetE;
        ctr_d[idx_e]    = 2'b10;
      end
    end
  end

  // Performance counters; non-branch stale predictions count as mispredicts
  always_comb begin
    branch_cnt_d  = branch_cnt_q;
    mispred_cnt_d = mispred_cnt_q;
    if (upd_e) begin
      branch_cnt_d = branch_cnt_q + 32'd1;
    end
    if (!StallE && MispredictE) begin
      mispred_cnt_d = mispred_cnt_q + 32'd1;
    end
  end

  // State registers with asynchronous active-low reset
  always_ff @(posedge CPU_CLK or negedge CPU_RST_N) begin
    if (!CPU_RST_N) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        ctr_q[i]    <= CNT_INIT;
      end
      branch_cnt_q  <= '0;
      mispred_cnt_q <= '0;
    end else begin
      valid_q       <= valid_d;
      tag_q         <= tag_d;
      target_q      <= target_d;
      ctr_q         <= ctr_d;
      branch_cnt_q  <= branch_cnt_d;
      mispred_cnt_q <= mispred_cnt_d;
    end
  end

  assign BranchCnt  = branch_cnt_q;
  assign MispredCnt = mispred_cnt_q;

endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench for branch_predictor (ENTRIES=64): learning, saturation,
// aliasing, stall gating, mispredict detection and async reset.
module tb_branch_predictor;

  logic        CPU_CLK = 1'b0;
  logic        CPU_RST_N;
  logic [31:0] PCF;
  logic        PredTakenF;
  logic [31:0] PredTargetF;
  logic [2:0]  BranchTypeE;
  logic        BranchE;
  logic [31:0] PCE;
  logic [31:0] BranchTargetE;
  logic        PredTakenE;
  logic [31:0] PredTargetE;
  logic        StallE;
  logic        MispredictE;
  logic [31:0] CorrectPCE;
  logic [31:0] BranchCnt;
  logic [31:0] MispredCnt;

  int n_assert = 0;
  int n_fail   = 0;

  branch_predictor #(.ENTRIES(64), .CNT_INIT(2'b01)) dut (
    .CPU_CLK      (CPU_CLK),
    .CPU_RST_N    (CPU_RST_N),
    .PCF          (PCF),
    .PredTakenF   (PredTakenF),
    .PredTargetF  (PredTargetF),
    .BranchTypeE  (BranchTypeE),
    .BranchE      (BranchE),
    .PCE          (PCE),
    .BranchTargetE(BranchTargetE),
    .PredTakenE   (PredTakenE),
    .PredTargetE  (PredTargetE),
    .StallE       (StallE),
    .MispredictE  (MispredictE),
    .CorrectPCE   (CorrectPCE),
    .BranchCnt    (BranchCnt),
    .MispredCnt   (MispredCnt)
  );

  always #5 CPU_CLK = ~CPU_CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic drv(input logic [2:0] bt, input logic [31:0] pce, input logic br,
                     input logic [31:0] tgt, input logic ptk, input logic [31:0] ptg);
    BranchTypeE   = bt;
    PCE           = pce;
    BranchE       = br;
    BranchTargetE = tgt;
    PredTakenE    = ptk;
    PredTargetE   = ptg;
  endtask

  task automatic idle();
    drv(3'd0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
  endtask

  task automatic step();
    @(posedge CPU_CLK);
    #1;
  endtask

  initial begin
    CPU_RST_N = 1'b1;
    StallE    = 1'b0;
    PCF       = 32'h100;
    idle();
    #1 CPU_RST_N = 1'b0;
    #2;
    // 1: reset state
    chk("rst_pred_taken", {31'b0, PredTakenF}, 32'h0);
    chk("rst_pred_target", PredTargetF, 32'h104);
    chk("rst_branch_cnt", BranchCnt, 32'h0);
    chk("rst_mispred_cnt", MispredCnt, 32'h0);
    @(negedge CPU_CLK);
    CPU_RST_N = 1'b1;
    step();

    // 2: first taken BEQ allocates
    drv(3'd1, 32'h100, 1'b1, 32'h80, 1'b0, 32'h104);
    #1;
    chk("t2_mispredict", {31'b0, MispredictE}, 32'h1);
    chk("t2_correct_pc", CorrectPCE, 32'h80);
    chk("t2_same_cycle_lookup", {31'b0, PredTakenF}, 32'h0);
    step();
    idle();
    #1;
    chk("t2_pred_taken", {31'b0, PredTakenF}, 32'h1);
    chk("t2_pred_target", PredTargetF, 32'h80);
    chk("t2_branch_cnt", BranchCnt, 32'd1);
    chk("t2_mispred_cnt", MispredCnt, 32'd1);

    // 3: saturate to 11, then two not-taken
    for (int i = 0; i < 3; i++) begin
      drv(3'd1, 32'h100, 1'b1, 32'h80, 1'b1, 32'h80);
      #1;
      chk("t3_correct_pred", {31'b0, MispredictE}, 32'h0);
      step();
    end
    drv(3'd1, 32'h100, 1'b0, 32'h80, 1'b1, 32'h80);
    #1;
    chk("t3_nt_mispredict", {31'b0, MispredictE}, 32'h1);
    chk("t3_nt_correct_pc", CorrectPCE, 32'h104);
    step();
    idle();
    #1;
    chk("t3_after_nt1_taken", {31'b0, PredTakenF}, 32'h1);
    drv(3'd1, 32'h100, 1'b0, 32'h80, 1'b1, 32'h80);
    step();
    idle();
    #1;
    chk("t3_after_nt2_taken", {31'b0, PredTakenF}, 32'h0);
    chk("t3_after_nt2_target", PredTargetF, 32'h104);
    chk("t3_branch_cnt", BranchCnt, 32'd6);
    chk("t3_mispred_cnt", MispredCnt, 32'd3);

    // 4: aliasing on index 0 (0x100 vs 0x200)
    drv(3'd1, 32'h100, 1'b1, 32'h80, 1'b0, 32'h104);
    step();
    idle();
    #1;
    chk("t4_0x100_retrained", {31'b0, PredTakenF}, 32'h1);
    drv(3'd1, 32'h200, 1'b1, 32'h300, 1'b0, 32'h204);
    step();
    idle();
    #1;
    chk("t4_0x100_evicted", {31'b0, PredTakenF}, 32'h0);
    chk("t4_0x100_target", PredTargetF, 32'h104);
    PCF = 32'h200;
    #1;
    chk("t4_0x200_taken", {31'b0, PredTakenF}, 32'h1);
    chk("t4_0x200_target", PredTargetF, 32'h300);
    // wrong target with correct direction
    drv(3'd1, 32'h200, 1'b1, 32'h300, 1'b1, 32'h304);
    #1;
    chk("t4_target_mispredict", {31'b0, MispredictE}, 32'h1);
    chk("t4_target_correct_pc", CorrectPCE, 32'h300);
    step();
    // taken prediction on a non-branch
    drv(3'd0, 32'h400, 1'b0, 32'h0, 1'b1, 32'h480);
    #1;
    chk("t4_stale_mispredict", {31'b0, MispredictE}, 32'h1);
    chk("t4_stale_correct_pc", CorrectPCE, 32'h404);
    step();
    idle();
    #1;
    chk("t4_branch_cnt", BranchCnt, 32'd9);
    chk("t4_mispred_cnt", MispredCnt, 32'd7);

    // 5: stalled BNE makes no change until released
    PCF    = 32'h504;
    StallE = 1'b1;
    drv(3'd2, 32'h504, 1'b1, 32'h600, 1'b0, 32'h508);
    #1;
    chk("t5_mispredict_in_stall", {31'b0, MispredictE}, 32'h1);
    step();
    step();
    step();
    chk("t5_stall_branch_cnt", BranchCnt, 32'd9);
    chk("t5_stall_mispred_cnt", MispredCnt, 32'd7);
    chk("t5_stall_no_alloc", {31'b0, PredTakenF}, 32'h0);
    StallE = 1'b0;
    step();
    idle();
    #1;
    chk("t5_release_branch_cnt", BranchCnt, 32'd10);
    chk("t5_release_mispred_cnt", MispredCnt, 32'd8);
    chk("t5_release_taken", {31'b0, PredTakenF}, 32'h1);
    chk("t5_release_target", PredTargetF, 32'h600);

    // 6: async reset between edges with an update pending
    PCF = 32'h200;
    @(negedge CPU_CLK);
    drv(3'd1, 32'h200, 1'b0, 32'h300, 1'b1, 32'h300);
    #1;
    chk("t6_pre_reset_taken", {31'b0, PredTakenF}, 32'h1);
    #1 CPU_RST_N = 1'b0;
    #1;
    chk("t6_reset_taken", {31'b0, PredTakenF}, 32'h0);
    chk("t6_reset_target", PredTargetF, 32'h204);
    chk("t6_reset_branch_cnt", BranchCnt, 32'h0);
    chk("t6_reset_mispred_cnt", MispredCnt, 32'h0);
    chk("t6_reset_mispredict_comb", {31'b0, MispredictE}, 32'h1);
    @(negedge CPU_CLK);
    CPU_RST_N = 1'b1;
    drv(3'd1, 32'h200, 1'b0, 32'h300, 1'b0, 32'h204);
    step();
    idle();
    #1;
    chk("t6_post_miss_taken", {31'b0, PredTakenF}, 32'h0);
    chk("t6_post_branch_cnt", BranchCnt, 32'd1);
    chk("t6_post_mispred_cnt", MispredCnt, 32'd0);
    PCF = 32'h504;
    #1;
    chk("t6_post_0x504_cleared", {31'b0, PredTakenF}, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
